// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli core and its SQI memory
// lanes.
//   sqi_data_t       one nibble on the SQI bus
//   sqi_mem_t        which memory lane an instance serves
//   sqi_cmd_t        the SQI instruction bytes the memory responds to
//   sqi_mem_state_t  control states of the memory-side responder
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic {
        SQI_MEM_LO = 1'b0,
        SQI_MEM_HI = 1'b1
    } sqi_mem_t;

    typedef enum logic [7:0] {
        SQI_CMD_WRITE = 8'h02,
        SQI_CMD_READ  = 8'h03
    } sqi_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } sqi_mem_state_t;

    // The address is always sent as 24 bits, i.e. six nibbles.
    localparam int unsigned SQI_ADDR_NIBBLES = 6;
    // Turnaround cycles between the last address nibble and read data.
    localparam int unsigned SQI_DUMMY_CYCLES = 2;

endpackage

// File: rtl/idli_sqi_ram.sv
// idli_sqi_ram: 2^ADDR_W x 8 byte array with one synchronous write port and
// one asynchronous read port. Kept separate so the SQI control logic does not
// depend on how a given FPGA flow infers RAM.
//   clk    write clock
//   we     write enable, sampled on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address (combinational read)
//   rdata  read data
module idli_sqi_ram #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // NOTE: the array has no reset; clearing it would block RAM inference and
    // its contents are meaningless until written (or preloaded).
    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/idli_sqi_mem.sv
// idli_sqi_mem: memory-side responder for one SQI lane. Decodes the serial
// READ (0x03) and WRITE (0x02) commands, holds a byte-addressed array and
// drives read data back on the nibble-wide bus. Fields arrive high nibble
// first, one nibble per rising edge while chip select is low.
//   i_clk         clock; the bus is sampled on the rising edge
//   i_rst         asynchronous active-high reset
//   i_sqi_cs_n    chip select, active low
//   i_sqi_sio     nibble from the core
//   o_sqi_sio     nibble to the core, 0 when not driving
//   o_sqi_sio_en  output enable for o_sqi_sio
// ADDR_W must lie between 5 and 24: the address is shifted in a nibble at a
// time and only the low ADDR_W bits are kept.
module idli_sqi_mem
    import idli_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sqi_cs_n,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_sio_en
);

    sqi_mem_state_t    state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    sqi_cmd_t          cmd_q, cmd_d;
    logic [3:0]        nib_q, nib_d;
    logic [3:0]        sio_d;
    logic              en_d;
    logic              we;
    logic              ram_we;
    logic [7:0]        instr;
    logic [7:0]        rd_data;

    // nib_q holds the first nibble of the instruction, then the high half of
    // each byte being written.
    assign instr = {nib_q, i_sqi_sio};

    // Reset must suppress the write in the very cycle it is asserted, so the
    // partial byte of an aborted transaction never reaches the array.
    assign ram_we = we & ~i_rst;

    idli_sqi_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata ({nib_q, i_sqi_sio}),
        .raddr (addr_q),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            cmd_q        <= SQI_CMD_READ;
            nib_q        <= '0;
            o_sqi_sio    <= '0;
            o_sqi_sio_en <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            nib_q        <= nib_d;
            o_sqi_sio    <= sio_d;
            o_sqi_sio_en <= en_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        nib_d   = nib_q;
        sio_d   = o_sqi_sio;
        en_d    = o_sqi_sio_en;
        we      = 1'b0;

        if (i_sqi_cs_n) begin
            // Deselect wins over everything and releases the bus.
            state_d = IDLE;
            cnt_d   = '0;
            sio_d   = '0;
            en_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    nib_d   = i_sqi_sio;
                    state_d = INSTR;
                end

                INSTR: begin
                    cnt_d = '0;
                    if (instr == SQI_CMD_READ || instr == SQI_CMD_WRITE) begin
                        cmd_d   = (instr == SQI_CMD_READ) ? SQI_CMD_READ : SQI_CMD_WRITE;
                        state_d = ADDR;
                    end else begin
                        state_d = IGNORE;
                    end
                end

                ADDR: begin
                    // Shifting drops the upper bits of the 24b address.
                    addr_d = {addr_q[ADDR_W-5:0], i_sqi_sio};
                    if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
                        cnt_d   = '0;
                        state_d = (cmd_q == SQI_CMD_READ) ? DUMMY : WRITE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                DUMMY: begin
                    if (cnt_q == 3'(SQI_DUMMY_CYCLES - 1)) begin
                        cnt_d   = '0;
                        sio_d   = rd_data[7:4];
                        en_d    = 1'b1;
                        state_d = READ;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                READ: begin
                    // cnt_q[0] = 0: the high nibble is on the bus, present
                    // the low one and advance so the next high nibble comes
                    // from the following byte.
                    if (!cnt_q[0]) begin
                        sio_d  = rd_data[3:0];
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = 3'd1;
                    end else begin
                        sio_d  = rd_data[7:4];
                        cnt_d  = '0;
                    end
                end

                WRITE: begin
                    if (!cnt_q[0]) begin
                        nib_d = i_sqi_sio;
                        cnt_d = 3'd1;
                    end else begin
                        we     = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = '0;
                    end
                end

                IGNORE: begin
                    state_d = IGNORE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// tb_idli_sqi_mem: directed bench for idli_sqi_mem (ADDR_W = 16). Inputs
// change on the falling edge; outputs are sampled on the same falling edge,
// so each sample shows what was registered at the rising edge that opened
// the current cycle.
module tb_idli_sqi_mem;

    logic       clk;
    logic       rst;
    logic       sqi_cs_n;
    logic [3:0] sqi_sio_in;
    logic [3:0] sqi_sio_out;
    logic       sqi_sio_en;

    int checks = 0;
    int errors = 0;

    idli_sqi_mem #(
        .ADDR_W (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sqi_cs_n   (sqi_cs_n),
        .i_sqi_sio    (sqi_sio_in),
        .o_sqi_sio    (sqi_sio_out),
        .o_sqi_sio_en (sqi_sio_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive the nibble the next rising edge will sample.
    task automatic step(input logic cs_n, input logic [3:0] nib);
        @(negedge clk);
        sqi_cs_n   = cs_n;
        sqi_sio_in = nib;
    endtask

    // Cycles 0-7: instruction then 24b address, high nibble first.
    task automatic send_header(input logic [7:0] instr, input logic [23:0] a);
        step(1'b0, instr[7:4]);
        step(1'b0, instr[3:0]);
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, a[i*4 +: 4]);
        end
    endtask

    // Write n nibbles (high first from data) then deselect.
    task automatic write_seq(input logic [23:0] a, input logic [31:0] data, input int n);
        send_header(8'h02, a);
        for (int k = 0; k < n; k++) begin
            step(1'b0, data[(n-1-k)*4 +: 4]);
        end
        step(1'b1, 4'h0);
    endtask

    // Read n nibbles, checking the dummy cycles and every data nibble, then
    // deselect and check that the bus is released.
    task automatic read_seq(input string tag, input logic [23:0] a,
                            input logic [31:0] exp, input int n);
        send_header(8'h03, a);
        step(1'b0, 4'h0);
        check({tag, " en cyc8"}, {7'd0, sqi_sio_en}, 8'h00);
        step(1'b0, 4'h0);
        check({tag, " en cyc9"}, {7'd0, sqi_sio_en}, 8'h00);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 4'h0);
            check($sformatf("%s sio cyc%0d", tag, 10 + k), {4'h0, sqi_sio_out},
                  {4'h0, exp[(n-1-k)*4 +: 4]});
            check($sformatf("%s en cyc%0d", tag, 10 + k), {7'd0, sqi_sio_en}, 8'h01);
        end
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        check({tag, " released sio"}, {4'h0, sqi_sio_out}, 8'h00);
        check({tag, " released en"}, {7'd0, sqi_sio_en}, 8'h00);
    endtask

    initial begin
        rst        = 1'b1;
        sqi_cs_n   = 1'b1;
        sqi_sio_in = 4'h0;

        // Preload contents used by the directed steps below.
        dut.u_ram.mem[16'h0020] = 8'h77;
        dut.u_ram.mem[16'h1234] = 8'h5E;
        dut.u_ram.mem[16'h0030] = 8'h99;
        dut.u_ram.mem[16'h0000] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset sio", {4'h0, sqi_sio_out}, 8'h00);
        check("reset en", {7'd0, sqi_sio_en}, 8'h00);
        rst = 1'b0;
        step(1'b1, 4'h0);

        // Basic write then read back A,5,3,C.
        write_seq(24'h000010, 32'h0000A53C, 4);
        check("wr mem[10]", dut.u_ram.mem[16'h0010], 8'hA5);
        check("wr mem[11]", dut.u_ram.mem[16'h0011], 8'h3C);
        read_seq("rd 10", 24'h000010, 32'h0000A53C, 4);

        // Address wrap at the top of the array.
        write_seq(24'h00FFFF, 32'h00001122, 4);
        check("wrap mem[FFFF]", dut.u_ram.mem[16'hFFFF], 8'h11);
        check("wrap mem[0000]", dut.u_ram.mem[16'h0000], 8'h22);
        read_seq("rd wrap", 24'h00FFFF, 32'h00001122, 4);

        // Upper address bits beyond ADDR_W are ignored.
        read_seq("rd FF1234", 24'hFF1234, 32'h0000005E, 2);

        // Unknown instruction 0x05: never drive, never write. The trailing
        // nibbles would look like "write FF to 0" if misdecoded.
        step(1'b0, 4'h0);
        step(1'b0, 4'h5);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, (k < 2) ? 4'h0 : 4'hF);
            check($sformatf("ignore en cyc%0d", k + 2), {7'd0, sqi_sio_en}, 8'h00);
        end
        step(1'b1, 4'h0);
        check("ignore mem[0000]", dut.u_ram.mem[16'h0000], 8'h22);
        check("ignore mem[0010]", dut.u_ram.mem[16'h0010], 8'hA5);

        // Write deselected after the high nibble only: byte unchanged, and a
        // read starting the very next cycle decodes cleanly.
        write_seq(24'h000020, 32'h0000000F, 1);
        check("partial mem[20]", dut.u_ram.mem[16'h0020], 8'h77);
        read_seq("rd after partial", 24'h000020, 32'h00000077, 2);

        // Reset during the second data nibble of a write drops the byte.
        send_header(8'h02, 24'h000030);
        step(1'b0, 4'h4);
        @(negedge clk);
        sqi_sio_in = 4'h1;
        rst        = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        sqi_cs_n = 1'b1;
        check("rst wr mem[30]", dut.u_ram.mem[16'h0030], 8'h99);
        read_seq("rd after rst wr", 24'h000030, 32'h00000099, 2);

        // Reset during cycle 11 of a read clears the outputs at once.
        send_header(8'h03, 24'h000010);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        check("rst rd sio cyc10", {4'h0, sqi_sio_out}, 8'h0A);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst rd sio", {4'h0, sqi_sio_out}, 8'h00);
        check("rst rd en", {7'd0, sqi_sio_en}, 8'h00);
        @(negedge clk);
        rst      = 1'b0;
        sqi_cs_n = 1'b1;
        read_seq("rd after rst rd", 24'h000011, 32'h0000003C, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
